kernel_kcore_v2h_hls_deadlock_report_unit: RTL and testbench

KERNEL_KCORE_V2H_HLS_DEADLOCK_REPORT_UNIT -- requirements
Module: kernel_kcore_v2h_hls_deadlock_report_unit

---
 rtl/kernel_kcore_v2h_hls_deadlock_pkg.sv | 14 +
 rtl/kernel_kcore_v2h_hls_deadlock_prio_enc.sv | 26 ++
 rtl/kernel_kcore_v2h_hls_deadlock_report_unit.sv | 171 +++++++++++++++++
 tb/tb_kernel_kcore_v2h_hls_deadlock_report_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/kernel_kcore_v2h_hls_deadlock_pkg.sv
// Shared definitions for the deadlock report unit: FSM state encoding and
// the default trace window length.
package kernel_kcore_v2h_hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_TRACE  = 2'd2,
    ST_REPORT = 2'd3
  } dl_state_e;

  localparam int DL_TRACE_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/kernel_kcore_v2h_hls_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder used to choose the origin process when
// several detect units flag a potential deadlock in the same cycle.
module kernel_kcore_v2h_hls_deadlock_prio_enc
  import kernel_kcore_v2h_hls_deadlock_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/kernel_kcore_v2h_hls_deadlock_report_unit.sv
// Deadlock report unit: picks an origin process from the detect units,
// arms it, follows the token around the dependence channels for a bounded
// number of cycles and presents a report (origin, channels seen, timeout)
// until it is acknowledged.
// Optional feature: define KERNEL_KCORE_V2H_DL_TIMESTAMP_EN to add a
// 32-bit report_time output holding the cycle count at trace start.
module kernel_kcore_v2h_hls_deadlock_report_unit
  import kernel_kcore_v2h_hls_deadlock_pkg::*;
#(
  parameter int PROC_NUM     = 4,
  parameter int CHAN_NUM     = 8,
  parameter int TRACE_CYCLES = DL_TRACE_CYCLES_DEFAULT
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PROC_NUM-1:0]         dl_detect_vec,
  input  logic [CHAN_NUM-1:0]         token_vec,
  input  logic                        ack,
  output logic                        dl_detect_in,
  output logic [PROC_NUM-1:0]         origin,
  output logic                        token_clear,
  output logic                        report_vld,
  output logic [$clog2(PROC_NUM)-1:0] report_origin,
  output logic [CHAN_NUM-1:0]         report_chan,
  output logic                        report_timeout
`ifdef KERNEL_KCORE_V2H_DL_TIMESTAMP_EN
  ,
  output logic [31:0]                 report_time
`endif
);

  localparam int IDX_W = $clog2(PROC_NUM);
  localparam int CNT_W = $clog2(TRACE_CYCLES + 1);

  dl_state_e           state_q, state_d;
  logic [IDX_W-1:0]    origin_idx_q, origin_idx_d;
  logic [CHAN_NUM-1:0] report_chan_q, report_chan_d;
  logic                report_timeout_q, report_timeout_d;
  logic [CNT_W-1:0]    trace_cnt_q, trace_cnt_d;

  logic [IDX_W-1:0]    enc_idx;
  logic                enc_vld;
  logic                closure;
  logic                expired;

  kernel_kcore_v2h_hls_deadlock_prio_enc #(
    .WIDTH (PROC_NUM),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (dl_detect_vec),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // Only the origin's own detect bit can close the cycle; other bits are noise.
  assign closure = dl_detect_vec[origin_idx_q];
  assign expired = (trace_cnt_q == '0);

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; closure takes priority over expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (enc_vld) state_d = ST_ARM;
      ST_ARM:    state_d = ST_TRACE;
      ST_TRACE:  if (closure || expired) state_d = ST_REPORT;
      ST_REPORT: if (ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode; token_clear fires in the same cycle the trace ends.
  always_comb begin
    dl_detect_in = 1'b0;
    origin       = '0;
    token_clear  = 1'b0;
    report_vld   = 1'b0;
    case (state_q)
      ST_ARM: begin
        dl_detect_in         = 1'b1;
        origin[origin_idx_q] = 1'b1;
      end
      ST_TRACE: begin
        dl_detect_in = 1'b1;
        token_clear  = closure | expired;
      end
      ST_REPORT: begin
        dl_detect_in = 1'b1;
        report_vld   = 1'b1;
      end
      default: ;
    endcase
  end

  // Report datapath: capture origin, accumulate channels, run the window counter.
  always_comb begin
    origin_idx_d     = origin_idx_q;
    report_chan_d    = report_chan_q;
    report_timeout_d = report_timeout_q;
    trace_cnt_d      = trace_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          origin_idx_d     = enc_idx;
          report_chan_d    = '0;
          report_timeout_d = 1'b0;
        end
      end
      ST_ARM: begin
        trace_cnt_d = CNT_W'(TRACE_CYCLES);
      end
      ST_TRACE: begin
        report_chan_d = report_chan_q | token_vec;
        trace_cnt_d   = expired ? '0 : trace_cnt_q - CNT_W'(1);
        if (closure)      report_timeout_d = 1'b0;
        else if (expired) report_timeout_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      origin_idx_q     <= '0;
      report_chan_q    <= '0;
      report_timeout_q <= 1'b0;
      trace_cnt_q      <= '0;
    end else begin
      origin_idx_q     <= origin_idx_d;
      report_chan_q    <= report_chan_d;
      report_timeout_q <= report_timeout_d;
      trace_cnt_q      <= trace_cnt_d;
    end
  end

  assign report_origin  = origin_idx_q;
  assign report_chan    = report_chan_q;
  assign report_timeout = report_timeout_q;

`ifdef KERNEL_KCORE_V2H_DL_TIMESTAMP_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] report_time_q, report_time_d;

  // Free-running cycle count, snapshotted when a trace is started.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 32'd1;
    report_time_d = report_time_q;
    if (state_q == ST_IDLE && enc_vld) report_time_d = cycle_cnt_q;
  end

  // Timestamp registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q   <= '0;
      report_time_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      report_time_q <= report_time_d;
    end
  end

  assign report_time = report_time_q;
`endif

endmodule

// File: tb/tb_kernel_kcore_v2h_hls_deadlock_report_unit.sv
// Bench for the deadlock report unit: directed and random traces, with
// expected reports queued by the stimulus and checked by a monitor.
module tb_kernel_kcore_v2h_hls_deadlock_report_unit;

  localparam int P = 4;
  localparam int C = 8;
  localparam int T = 16;

  typedef struct {
    int          idx;
    logic [C-1:0] chan;
    logic        timeout;
  } report_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [P-1:0]         dl_detect_vec = '0;
  logic [C-1:0]         token_vec = '0;
  logic                 ack = 1'b0;
  logic                 dl_detect_in;
  logic [P-1:0]         origin;
  logic                 token_clear;
  logic                 report_vld;
  logic [$clog2(P)-1:0] report_origin;
  logic [C-1:0]         report_chan;
  logic                 report_timeout;
`ifdef KERNEL_KCORE_V2H_DL_TIMESTAMP_EN
  logic [31:0]          report_time;
`endif

  int checks = 0;
  int errors = 0;
  report_t exp_q[$];

  kernel_kcore_v2h_hls_deadlock_report_unit #(
    .PROC_NUM(P), .CHAN_NUM(C), .TRACE_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset), .dl_detect_vec(dl_detect_vec),
    .token_vec(token_vec), .ack(ack), .dl_detect_in(dl_detect_in),
    .origin(origin), .token_clear(token_clear), .report_vld(report_vld),
    .report_origin(report_origin), .report_chan(report_chan),
    .report_timeout(report_timeout)
`ifdef KERNEL_KCORE_V2H_DL_TIMESTAMP_EN
    , .report_time(report_time)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowestSet(input logic [P-1:0] v);
    for (int i = 0; i < P; i++) if (v[i]) return i;
    return -1;
  endfunction

  // One full trace: detect, arm, follow the token, report, acknowledge.
  // close_at is the TRACE cycle (1-based) in which the origin bit returns;
  // values beyond T+1 mean it never returns inside the window.
  task automatic applyStimulus(input logic [P-1:0] detect, input int close_at,
                               input int ack_delay, input bit directed);
    int           idx;
    logic [P-1:0] onehot;
    logic [C-1:0] chan;
    logic [C-1:0] tok;
    bit           done;
    report_t      r;
    idx    = lowestSet(detect);
    onehot = '0;
    onehot[idx] = 1'b1;
    chan   = '0;
    // IDLE: raise the detect vector
    @(negedge clock);
    dl_detect_vec = detect;
    token_vec     = '0;
    ack           = directed ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    checkOutput("idle_dl_detect_in", 32'(dl_detect_in), 0);
    // ARM
    @(negedge clock);
    dl_detect_vec = directed ? '0 : P'($urandom);
    ack           = directed ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    checkOutput("arm_origin", 32'(origin), 32'(onehot));
    checkOutput("arm_dl_detect_in", 32'(dl_detect_in), 1);
    checkOutput("arm_report_origin", 32'(report_origin), 32'(idx));
    checkOutput("arm_token_clear", 32'(token_clear), 0);
    // TRACE
    done = 1'b0;
    for (int t = 1; t <= T + 1 && !done; t++) begin
      @(negedge clock);
      if (directed) tok = (t == 1) ? C'(8'h01) : (t == 2) ? C'(8'h04) : '0;
      else          tok = C'($urandom);
      token_vec     = tok;
      dl_detect_vec = directed ? '0 : (P'($urandom) & ~onehot);
      if (t == close_at) dl_detect_vec = dl_detect_vec | onehot;
      ack           = directed ? 1'b0 : 1'($urandom_range(0, 1));
      chan          = chan | tok;
      done          = (t == close_at) || (t == T + 1);
      #1;
      checkOutput("trace_origin", 32'(origin), 0);
      checkOutput("trace_dl_detect_in", 32'(dl_detect_in), 1);
      checkOutput("trace_token_clear", 32'(token_clear), 32'(done));
      if (done) begin
        r.idx     = idx;
        r.chan    = chan;
        r.timeout = (t != close_at);
        exp_q.push_back(r);
      end
    end
    // REPORT: hold ack low for a while, then acknowledge
    for (int d = 0; d <= ack_delay; d++) begin
      @(negedge clock);
      dl_detect_vec = '0;
      token_vec     = directed ? '0 : C'($urandom);
      ack           = (d == ack_delay);
      #1;
      checkOutput("report_vld_held", 32'(report_vld), 1);
    end
    @(negedge clock);
    ack       = 1'b0;
    token_vec = '0;
    #1;
    checkOutput("after_ack_vld", 32'(report_vld), 0);
    checkOutput("after_ack_dl_detect_in", 32'(dl_detect_in), 0);
  endtask

  // Monitor: pop an expectation on each new report and check it while held.
  bit      prev_vld = 1'b0;
  bit      have_cur = 1'b0;
  report_t cur;
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (report_vld) begin
        if (!prev_vld) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_report", 32'(report_vld), 0);
            have_cur = 1'b0;
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          checkOutput("mon_report_origin", 32'(report_origin), 32'(cur.idx));
          checkOutput("mon_report_chan", 32'(report_chan), 32'(cur.chan));
          checkOutput("mon_report_timeout", 32'(report_timeout), 32'(cur.timeout));
        end
      end
      prev_vld = report_vld;
    end
  end

  initial begin
    logic [P-1:0] det;
    // Reset state
    #12;
    checkOutput("rst_dl_detect_in", 32'(dl_detect_in), 0);
    checkOutput("rst_origin", 32'(origin), 0);
    checkOutput("rst_report_vld", 32'(report_vld), 0);
    checkOutput("rst_report_chan", 32'(report_chan), 0);
    checkOutput("rst_report_timeout", 32'(report_timeout), 0);
    @(negedge clock);
    reset = 1'b1;

    // Directed: origin from 4'b0110, tokens 01 then 04, closure on cycle 3
    applyStimulus(4'b0110, 3, 1, 1'b1);
    // Directed: no closure, timeout after the full window
    applyStimulus(4'b1000, 99, 0, 1'b1);
    // Directed: closure coincident with counter reaching zero
    applyStimulus(4'b0001, T + 1, 2, 1'b0);
    // Directed: closure one cycle before expiry
    applyStimulus(4'b1100, T, 0, 1'b0);

    // Reset pulse mid-TRACE aborts without a report
    @(negedge clock);
    dl_detect_vec = 4'b0100;
    @(negedge clock);
    dl_detect_vec = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midrst_dl_detect_in", 32'(dl_detect_in), 0);
    checkOutput("midrst_token_clear", 32'(token_clear), 0);
    checkOutput("midrst_report_chan", 32'(report_chan), 0);
    checkOutput("midrst_report_origin", 32'(report_origin), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (T + 4) @(negedge clock);
    #1;
    checkOutput("postrst_report_vld", 32'(report_vld), 0);
    checkOutput("postrst_dl_detect_in", 32'(dl_detect_in), 0);

    // Random traces
    for (int n = 0; n < 30; n++) begin
      det = P'($urandom_range(1, (1 << P) - 1));
      applyStimulus(det, $urandom_range(1, T + 5), $urandom_range(0, 3), 1'b0);
    end

    repeat (3) @(negedge clock);
    checkOutput("outstanding_reports", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
